video_serial_rx: RTL and testbench
==================================

# video_serial_rx

Receiver for the one-way serial display link: display reset, serial clock (idle high) and MSB-first serial data. It deserializes the link in the `in_clk` domain and delivers init bytes, then 16-bit pixels tagged with their x/y position, as single-cycle write strobes. It serves as the display-side model in simulation and as a bridge into an on-chip framebuffer or a second display driver.

## Interface
- `SERIAL_BITS`, 8, bits per serial word.
- `PIXEL_BITS`, 16, pixel width. Must equal 2*`SERIAL_BITS`. Sent high byte first.
- `SCREEN_WIDTH`, 128, pixels per line.
- `SCREEN_HEIGHT`, 64, lines per frame.
- `INIT_BYTES`, 2, number of init bytes after each display reset.
- `IDLE_TIMEOUT`, 256, `in_clk` cycles of serial clock held high that abort a partial word.
- `HCTR_BITS`, $clog2(`SCREEN_WIDTH`), x counter width.
- `VCTR_BITS`, $clog2(`SCREEN_HEIGHT`), y counter width.
- Ports:
  - `in_clk` in 1: system clock. It must run at least 4× the serial clock.
  - `in_rst` in 1: reset. One clock; reset is synchronous and active-low.
  - `in_vid_rst` in 1: display reset from the link, active high, asynchronous to `in_clk`.
  - `in_vid_serial_clk` in 1: serial clock, idle high, asynchronous.
  - `in_vid_serial` in 1: serial data, idle low, MSB first.
  - `out_init_byte` out `SERIAL_BITS`: received init byte.
  - `out_init_idx` out $clog2(`INIT_BYTES`)+1: index of the init byte.
  - `out_init_we` out 1: one-cycle strobe qualifying `out_init_byte` and `out_init_idx`.
  - `out_pixel` out `PIXEL_BITS`: assembled pixel.
  - `out_hpix` out `HCTR_BITS`: x position of `out_pixel`.
  - `out_vpix` out `VCTR_BITS`: y position of `out_pixel`.
  - `out_pixel_we` out 1: one-cycle strobe qualifying `out_pixel`, `out_hpix` and `out_vpix`.
  - `out_frame_done` out 1: level, high once the last pixel of the frame is written.
  - `out_err` out 1: sticky flag for a partial word aborted by timeout.

## Operation
- **Input synchronization.**
  - Each of the three link inputs passes through two flip-flops.
  - A third flip-flop on the clock line gives the previous value.
  - `rise` = synchronized clock high while the previous value is low.
- **Bit capture.**
  - On `rise`, shift synchronized data into the shift register from the LSB end, so the MSB arrives first.
  - Increment the bit counter on each `rise`.
  - On the `SERIAL_BITS`-th bit, raise a word-complete event, clear the counter and latch the word.
- **Idle timeout.**
  - The idle counter counts cycles with the synchronized clock high.
  - It clears on any low cycle.
  - When it reaches `IDLE_TIMEOUT` with the bit counter nonzero: clear the bit counter and shift register, and set `out_err`.
  - `out_err` is cleared only by `in_rst` or by a display reset.
- **State machine.** States are Reset, RecvInit, RecvHigh, RecvLow, Done.
  - Reset: counters cleared. Leave on the first cycle with synchronized `in_vid_rst` = 0: go to RecvInit if `INIT_BYTES` > 0, otherwise RecvHigh.
  - RecvInit, on word complete:
    - Strobe `out_init_we` with `out_init_idx` = init counter.
    - If the counter is `INIT_BYTES`-1, go to RecvHigh; otherwise increment the counter.
  - RecvHigh: on word complete, store the high byte and go to RecvLow.
  - RecvLow, on word complete:
    - Strobe `out_pixel_we` with `out_pixel` = {high, word} and the current x/y.
    - Advance position: x+1. At x = `SCREEN_WIDTH`-1, x returns to 0 and y increments.
    - At the last pixel (x = `SCREEN_WIDTH`-1, y = `SCREEN_HEIGHT`-1), go to Done.
    - Otherwise go to RecvHigh.
  - Done: `out_frame_done` = 1. Words are ignored: no strobes, no `out_err` change.
- **Display reset.** Synchronized `in_vid_rst` = 1 in any state forces Reset the next cycle. This:
  - discards any partial word and any held high byte;
  - clears x, y, the init counter, the bit counter, the idle counter, `out_frame_done` and `out_err`.
- **Width rules.** x and y compare against parameters at full integer width, so non-power-of-2 sizes are legal.

## Timing
- **Reset values.** On `in_rst` = 0 at a clock edge:
  - state = Reset;
  - all outputs 0, including strobes, data, x/y, `out_frame_done` and `out_err`;
  - all synchronizer flip-flops take the idle values: clock 1, data 0, display reset 1.
- **Strobe latency.** Label as cycle 0 the cycle in which the first synchronizer stage captures the serial clock rise carrying the last bit of a word. The `out_init_we` or `out_pixel_we` strobe is high during cycle 3, for exactly one cycle.
- **Output hold.** Data, index and x/y are valid in the strobe cycle and hold until the next strobe.
- **Data setup.** Link data must be stable from at least 2 `in_clk` cycles before each serial clock rise until 2 cycles after it.
- **Back-to-back words.** Consecutive words are accepted back to back with no gap requirement beyond `SERIAL_BITS` serial periods.
- **Simultaneous events.** If a display reset and a word complete land in the same cycle, the reset wins and no strobe is issued.
- **Timeout and rise together.** If the timeout and a `rise` fall in the same cycle, the `rise` wins and the counter clears.

## Test plan
- **Init bytes.** Apply display reset, then release it and send 0xFF, 0x00 at a 1:50 clock ratio. Require `out_init_we` twice: idx 0 with byte 0xFF, then idx 1 with byte 0x00.
- **Single pixel.** After init, send 0xF8, 0x1F. Require one `out_pixel_we` with `out_pixel` = 0xF81F, x = 0, y = 0, strobing 3 cycles after the final rise is first sampled.
- **Full frame.** Use `SCREEN_WIDTH` = 4, `SCREEN_HEIGHT` = 2 and send 8 pixels with values 0x0000–0x0007.
  - Require x/y sequence (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1).
  - Require `out_frame_done` = 1 after the last pixel.
  - A 9th pixel produces no strobe.
- **Timeout.** Send 5 bits, then hold the clock high for `IDLE_TIMEOUT` cycles.
  - Require `out_err` = 1 and no strobe.
  - A following full pixel 0x1234 must be received correctly at the expected x/y.
- **Display reset mid-pixel.** After the high byte of pixel 3, pulse `in_vid_rst`.
  - Require x = y = 0, `out_err` = 0, state Reset.
  - A fresh init sequence plus one pixel must give idx 0/1 and then a pixel at (0,0).
- **System reset mid-word.** Pull `in_rst` low mid-word. Require all outputs 0 in the next cycle; operation resumes only after the display reset is released.

Source files
------------

// File: rtl/video_serial_rx.sv
// Serial display link receiver: synchronizes the link, deserializes MSB-first
// words and emits init-byte and positioned-pixel write strobes.
module video_serial_rx #(
    parameter int SERIAL_BITS   = 8,
    parameter int PIXEL_BITS    = 16,
    parameter int SCREEN_WIDTH  = 128,
    parameter int SCREEN_HEIGHT = 64,
    parameter int INIT_BYTES    = 2,
    parameter int IDLE_TIMEOUT  = 256,
    parameter int HCTR_BITS     = $clog2(SCREEN_WIDTH),
    parameter int VCTR_BITS     = $clog2(SCREEN_HEIGHT)
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic                          in_vid_rst,
    input  logic                          in_vid_serial_clk,
    input  logic                          in_vid_serial,
    output logic [SERIAL_BITS-1:0]        out_init_byte,
    output logic [$clog2(INIT_BYTES):0]   out_init_idx,
    output logic                          out_init_we,
    output logic [PIXEL_BITS-1:0]         out_pixel,
    output logic [HCTR_BITS-1:0]          out_hpix,
    output logic [VCTR_BITS-1:0]          out_vpix,
    output logic                          out_pixel_we,
    output logic                          out_frame_done,
    output logic                          out_err
);

    localparam int IdxBits  = $clog2(INIT_BYTES) + 1;
    localparam int BcntBits = $clog2(SERIAL_BITS);
    localparam int IdleBits = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StReset,
        StRecvInit,
        StRecvHigh,
        StRecvLow,
        StDone
    } state_t;

    // Synchronizer stages; clk_s3 is the previous value of the synchronized clock.
    logic clk_s1, clk_s2, clk_s3;
    logic dat_s1, dat_s2;
    logic vrst_s1, vrst_s2;
    logic rise;

    // Two-flop synchronizers, reset to the idle link levels.
    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            dat_s1  <= 1'b0;
            dat_s2  <= 1'b0;
            vrst_s1 <= 1'b1;
            vrst_s2 <= 1'b1;
        end else begin
            clk_s1  <= in_vid_serial_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            dat_s1  <= in_vid_serial;
            dat_s2  <= dat_s1;
            vrst_s1 <= in_vid_rst;
            vrst_s2 <= vrst_s1;
        end
    end

    assign rise = clk_s2 & ~clk_s3;

    // Bit capture. The shift register only holds the first SERIAL_BITS-1 bits;
    // the final bit is merged straight into the latched word.
    logic [SERIAL_BITS-2:0] shift_q;
    logic [SERIAL_BITS-1:0] shift_next;
    logic [SERIAL_BITS-1:0] word_q;
    logic                   word_done_q;
    logic [BcntBits-1:0]    bit_cnt_q;
    logic [IdleBits-1:0]    idle_cnt_q;
    logic                   timeout_hit;

    assign shift_next  = {shift_q, dat_s2};
    // A rise always finds the idle counter freshly cleared, but keep rise dominant.
    assign timeout_hit = (int'(idle_cnt_q) == IDLE_TIMEOUT) && (bit_cnt_q != '0) && !rise;

    // Shift in bits on serial clock rises and abort partial words on idle timeout.
    always_ff @(posedge in_clk) begin
        if (!in_rst || vrst_s2) begin
            shift_q     <= '0;
            word_q      <= '0;
            word_done_q <= 1'b0;
            bit_cnt_q   <= '0;
            idle_cnt_q  <= '0;
        end else begin
            word_done_q <= 1'b0;
            if (!clk_s2) begin
                idle_cnt_q <= '0;
            end else if (int'(idle_cnt_q) != IDLE_TIMEOUT) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end
            if (rise) begin
                shift_q <= shift_next[SERIAL_BITS-2:0];
                if (int'(bit_cnt_q) == SERIAL_BITS - 1) begin
                    word_q      <= shift_next;
                    word_done_q <= 1'b1;
                    bit_cnt_q   <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end else if (timeout_hit) begin
                shift_q   <= '0;
                bit_cnt_q <= '0;
            end
        end
    end

    // Frame state and registered outputs.
    state_t                  state_q, state_d;
    logic [HCTR_BITS-1:0]    x_q, x_d;
    logic [VCTR_BITS-1:0]    y_q, y_d;
    logic [IdxBits-1:0]      init_cnt_q, init_cnt_d;
    logic [SERIAL_BITS-1:0]  high_q, high_d;
    logic [SERIAL_BITS-1:0]  init_byte_q, init_byte_d;
    logic [IdxBits-1:0]      init_idx_q, init_idx_d;
    logic                    init_we_q, init_we_d;
    logic [PIXEL_BITS-1:0]   pixel_q, pixel_d;
    logic [HCTR_BITS-1:0]    hpix_q, hpix_d;
    logic [VCTR_BITS-1:0]    vpix_q, vpix_d;
    logic                    pixel_we_q, pixel_we_d;
    logic                    frame_done_q, frame_done_d;
    logic                    err_q, err_d;

    // Next-state and output decode; display reset overrides everything.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        init_cnt_d   = init_cnt_q;
        high_d       = high_q;
        init_byte_d  = init_byte_q;
        init_idx_d   = init_idx_q;
        init_we_d    = 1'b0;
        pixel_d      = pixel_q;
        hpix_d       = hpix_q;
        vpix_d       = vpix_q;
        pixel_we_d   = 1'b0;
        frame_done_d = frame_done_q;
        err_d        = err_q;

        if (vrst_s2) begin
            state_d      = StReset;
            x_d          = '0;
            y_d          = '0;
            init_cnt_d   = '0;
            high_d       = '0;
            frame_done_d = 1'b0;
            err_d        = 1'b0;
        end else begin
            if (timeout_hit && state_q != StDone) begin
                err_d = 1'b1;
            end
            case (state_q)
                StReset: begin
                    x_d        = '0;
                    y_d        = '0;
                    init_cnt_d = '0;
                    state_d    = (INIT_BYTES > 0) ? StRecvInit : StRecvHigh;
                end
                StRecvInit: begin
                    if (word_done_q) begin
                        init_we_d   = 1'b1;
                        init_byte_d = word_q;
                        init_idx_d  = init_cnt_q;
                        if (int'(init_cnt_q) == INIT_BYTES - 1) begin
                            state_d = StRecvHigh;
                        end else begin
                            init_cnt_d = init_cnt_q + 1'b1;
                        end
                    end
                end
                StRecvHigh: begin
                    if (word_done_q) begin
                        high_d  = word_q;
                        state_d = StRecvLow;
                    end
                end
                StRecvLow: begin
                    if (word_done_q) begin
                        pixel_we_d = 1'b1;
                        pixel_d    = {high_q, word_q};
                        hpix_d     = x_q;
                        vpix_d     = y_q;
                        state_d    = StRecvHigh;
                        if (int'(x_q) == SCREEN_WIDTH - 1) begin
                            x_d = '0;
                            if (int'(y_q) == SCREEN_HEIGHT - 1) begin
                                y_d          = '0;
                                state_d      = StDone;
                                frame_done_d = 1'b1;
                            end else begin
                                y_d = y_q + 1'b1;
                            end
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    frame_done_d = 1'b1;
                end
                default: begin
                    state_d = StReset;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            state_q      <= StReset;
            x_q          <= '0;
            y_q          <= '0;
            init_cnt_q   <= '0;
            high_q       <= '0;
            init_byte_q  <= '0;
            init_idx_q   <= '0;
            init_we_q    <= 1'b0;
            pixel_q      <= '0;
            hpix_q       <= '0;
            vpix_q       <= '0;
            pixel_we_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            init_cnt_q   <= init_cnt_d;
            high_q       <= high_d;
            init_byte_q  <= init_byte_d;
            init_idx_q   <= init_idx_d;
            init_we_q    <= init_we_d;
            pixel_q      <= pixel_d;
            hpix_q       <= hpix_d;
            vpix_q       <= vpix_d;
            pixel_we_q   <= pixel_we_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign out_init_byte  = init_byte_q;
    assign out_init_idx   = init_idx_q;
    assign out_init_we    = init_we_q;
    assign out_pixel      = pixel_q;
    assign out_hpix       = hpix_q;
    assign out_vpix       = vpix_q;
    assign out_pixel_we   = pixel_we_q;
    assign out_frame_done = frame_done_q;
    assign out_err        = err_q;

endmodule

// File: tb/tb_video_serial_rx.sv
// Directed bench for video_serial_rx on a 4x2 screen with a 1:50 serial clock ratio.
module tb_video_serial_rx;

    localparam int HALF = 25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vid_rst = 1'b1;
    logic        sclk = 1'b1;
    logic        sdat = 1'b0;
    logic [7:0]  init_byte;
    logic [1:0]  init_idx;
    logic        init_we;
    logic [15:0] pixel;
    logic [1:0]  hpix;
    logic [0:0]  vpix;
    logic        pixel_we;
    logic        frame_done;
    logic        err;

    video_serial_rx #(
        .SERIAL_BITS   (8),
        .PIXEL_BITS    (16),
        .SCREEN_WIDTH  (4),
        .SCREEN_HEIGHT (2),
        .INIT_BYTES    (2),
        .IDLE_TIMEOUT  (256)
    ) dut (
        .in_clk            (clk),
        .in_rst            (rst_n),
        .in_vid_rst        (vid_rst),
        .in_vid_serial_clk (sclk),
        .in_vid_serial     (sdat),
        .out_init_byte     (init_byte),
        .out_init_idx      (init_idx),
        .out_init_we       (init_we),
        .out_pixel         (pixel),
        .out_hpix          (hpix),
        .out_vpix          (vpix),
        .out_pixel_we      (pixel_we),
        .out_frame_done    (frame_done),
        .out_err           (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int last_rise = 0;

    logic [7:0]  ib_log [64];
    int          ii_log [64];
    int          n_init = 0;
    logic [15:0] px_log [64];
    int          hx_log [64];
    int          vy_log [64];
    int          pc_log [64];
    int          n_pix = 0;

    // Log every strobe away from the active edge.
    always @(negedge clk) begin
        if (init_we) begin
            if (n_init < 64) begin
                ib_log[n_init] = init_byte;
                ii_log[n_init] = int'(init_idx);
            end
            n_init++;
        end
        if (pixel_we) begin
            if (n_pix < 64) begin
                px_log[n_pix] = pixel;
                hx_log[n_pix] = int'(hpix);
                vy_log[n_pix] = int'(vpix);
                pc_log[n_pix] = cyc;
            end
            n_pix++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_init(input string tag, input int k, input int idx, input logic [7:0] b);
        if (k < n_init) begin
            check_eq({tag, "_idx"}, ii_log[k], idx);
            check_eq({tag, "_byte"}, ib_log[k], b);
        end else begin
            check_eq({tag, "_missing"}, n_init, k + 1);
        end
    endtask

    task automatic check_pix(input string tag, input int k, input logic [15:0] p,
                             input int x, input int y);
        if (k < n_pix) begin
            check_eq({tag, "_pix"}, px_log[k], p);
            check_eq({tag, "_x"}, hx_log[k], x);
            check_eq({tag, "_y"}, vy_log[k], y);
        end else begin
            check_eq({tag, "_missing"}, n_pix, k + 1);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        sclk = 1'b0;
        sdat = b;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        last_rise = cyc;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_pixel(input logic [15:0] p);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
    endtask

    task automatic vid_reset_pulse();
        @(negedge clk);
        vid_rst = 1'b1;
        repeat (10) @(negedge clk);
        vid_rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int base;
        // System reset state
        repeat (5) @(negedge clk);
        check_eq("rst_init_we", init_we, 0);
        check_eq("rst_pixel_we", pixel_we, 0);
        check_eq("rst_outs", {init_byte, init_idx, pixel, hpix, vpix}, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("vrst_hold_no_strobe", n_init + n_pix, 0);
        vid_rst = 1'b0;
        repeat (10) @(negedge clk);

        // Init bytes
        send_byte(8'hFF);
        send_byte(8'h00);
        check_eq("init_count", n_init, 2);
        check_init("init0", 0, 0, 8'hFF);
        check_init("init1", 1, 1, 8'h00);

        // Single pixel with strobe latency
        send_pixel(16'hF81F);
        check_eq("px0_count", n_pix, 1);
        check_pix("px0", 0, 16'hF81F, 0, 0);
        check_eq("px0_latency", pc_log[0], last_rise + 4);
        check_eq("px0_hold", pixel, 16'hF81F);

        // Partial word aborted by idle timeout
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        repeat (300) @(negedge clk);
        check_eq("to_err", err, 1);
        check_eq("to_no_strobe", n_pix, 1);
        send_pixel(16'h1234);
        check_pix("to_px", 1, 16'h1234, 1, 0);
        check_eq("to_err_sticky", err, 1);

        // Display reset after the high byte of pixel 3
        send_pixel(16'h0002);
        check_pix("px2", 2, 16'h0002, 2, 0);
        send_byte(8'hCC);
        vid_reset_pulse();
        check_eq("vr_err", err, 0);
        check_eq("vr_frame_done", frame_done, 0);
        check_eq("vr_no_strobe", n_pix, 3);
        send_byte(8'hA5);
        send_byte(8'h5A);
        check_init("vr_init0", 2, 0, 8'hA5);
        check_init("vr_init1", 3, 1, 8'h5A);
        send_pixel(16'hBEEF);
        check_pix("vr_px", 3, 16'hBEEF, 0, 0);

        // Full 4x2 frame
        vid_reset_pulse();
        send_byte(8'h01);
        send_byte(8'h02);
        base = n_pix;
        for (int k = 0; k < 8; k++) begin
            send_pixel(16'(k));
            check_pix($sformatf("frm%0d", k), base + k, 16'(k), k % 4, k / 4);
            if (k == 6) check_eq("frm_not_done", frame_done, 0);
        end
        check_eq("frm_done", frame_done, 1);
        send_pixel(16'h0009);
        check_eq("frm_extra_no_strobe", n_pix, base + 8);
        check_eq("frm_done_hold", frame_done, 1);

        // System reset in the middle of a word
        for (int i = 0; i < 4; i++) send_bit(~i[0]);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("srst_outs", {init_byte, init_idx, pixel, hpix, vpix}, 0);
        check_eq("srst_flags", {init_we, pixel_we, frame_done, err}, 0);
        rst_n = 1'b1;
        vid_reset_pulse();
        base = n_init;
        send_byte(8'h11);
        send_byte(8'h22);
        check_init("srst_init0", base, 0, 8'h11);
        check_init("srst_init1", base + 1, 1, 8'h22);
        base = n_pix;
        send_pixel(16'h00AB);
        check_pix("srst_px", base, 16'h00AB, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
